quad_step_tx: RTL and testbench
===============================

Name: quad_step_tx

Overview:
Quadrature transmitter: converts step commands (count + direction) into a two-phase Gray-coded A/B waveform. Edge spacing is set by a parameter so a downstream debounce/direction decoder sees clean, stable levels. Used as an on-chip encoder emulator for loopback testing of the rotary-input path, and as a quadrature drive source. Holds a signed-agnostic 16-bit position counter of emitted steps.

Parameters:
DWELL, 100, clk cycles between consecutive A/B edges; legal range >= 2; must exceed the receiver debounce count (80)
CW, 8, width of the cmd_steps field
PPR, 24, pulses per revolution for the index output (used only with QTX_INDEX_EN)

Ports:
clk  input  1  system clock (10 MHz at top level)
rst  input  1  asynchronous, active-low reset
cmd_valid  input  1  step command present
cmd_ready  output  1  block can accept a command
cmd_dir  input  1  1 = forward (A leads B), 0 = reverse
cmd_steps  input  CW  number of quadrature steps to emit; 0 is legal
a  output  1  phase A, registered
b  output  1  phase B, registered
busy  output  1  command in progress
done  output  1  one-cycle pulse at command completion
pos  output  16  step position counter, wraps modulo 2^16

Behaviour:
- One clock. Reset is asynchronous and active-low (rst=0 resets). All outputs are registered.
- Reset values: a=0, b=0, pos=0, busy=0, done=0, cmd_ready=1, FSM in IDLE.
- Forward Gray sequence on {a,b}: 00 -> 10 -> 11 -> 01 -> 00. Reverse is the same sequence traversed backwards. Each step changes exactly one bit.
- pos increments by 1 on each forward step and decrements by 1 on each reverse step. It wraps: FFFF+1 -> 0000 and 0000-1 -> FFFF.
- Handshake: a command is accepted on a rising clk edge where cmd_valid=1 and cmd_ready=1. cmd_ready=1 only in IDLE. cmd_valid while busy is ignored, and no queueing is performed.
- FSM states: IDLE, STEP, HOLD, DONE.
  - IDLE: cmd_ready=1, busy=0.
    - On accept with cmd_steps != 0: latch dir, set remaining = cmd_steps, go to STEP.
    - On accept with cmd_steps == 0: go to DONE. No edge is emitted and pos is unchanged.
  - STEP (1 cycle): advance {a,b} one position in the latched direction, update pos, decrement remaining, load the dwell timer, go to HOLD.
  - HOLD: count down the timer so that consecutive edges are exactly DWELL cycles apart. On expiry, go to STEP if remaining != 0, otherwise go to DONE.
  - DONE (1 cycle): done=1 and busy=0. Next state is IDLE, so cmd_ready is high on the following cycle.
- busy=1 from the cycle after accept through the last HOLD cycle.
- Timing: with accept at edge t, the first A/B change is visible after edge t+1. Step k (k=1..N) lands at t+1+(k-1)*DWELL. done is high for the cycle after edge t+1+N*DWELL.
- A zero-step command produces done one cycle after accept, in the DONE state.
- Back-to-back commands: the earliest next edge is t_done+2 after the next accept. Spacing across commands is therefore >= DWELL and is never shorter.
- Reset mid-command: {a,b} is forced to 00 immediately, which may produce a simultaneous 2-bit change. The command is aborted with no done pulse. pos returns to 0.
- remaining is CW bits wide. The maximum command is 2^CW - 1 steps.

Optional Feature:
QTX_INDEX_EN
- With the macro defined: adds output z (1 bit, registered) and internal phase counter idx with range 0..4*PPR-1.
  - idx increments on forward steps and decrements on reverse steps, wrapping at both ends (4*PPR-1 <-> 0).
  - z=1 exactly while idx==0.
  - Reset sets idx=0, so z=1 out of reset.
- Without the macro: no z port, no idx logic, and PPR is unused.

Test Plan:
(All scenarios use DWELL=4, CW=8.)
- Reset release, then idle for 20 cycles -> a=b=0, pos=0, cmd_ready=1, busy=0, done never asserted.
- Accept at cycle 0 with dir=1, steps=3 -> {a,b}=10 at cycle 1, 11 at cycle 5, 01 at cycle 9; done=1 at cycle 13; pos=0003; busy high over cycles 1..12.
- Starting from {a,b}=01 and pos=3, send dir=0, steps=2 -> sequence 11 then 10, spaced exactly 4 cycles apart; pos=0001. Then dir=0, steps=2 -> 00, 01; pos=FFFF (wrap).
- Send steps=0 -> done one cycle after accept, no A/B change, pos unchanged. Hold cmd_valid high during a busy command -> second command is not accepted until IDLE.
- Assert rst between the 2nd and 3rd step of a 5-step command -> a=b=0, pos=0, no done pulse. A new command after release behaves per scenario 2.
- With QTX_INDEX_EN and PPR=2: 8 forward steps from reset -> z=1 at start, 0 during steps 1..7, 1 after step 8. One reverse step -> z=0 and idx=7.

Source files
------------

// File: rtl/quad_step_tx_if.sv
// quad_step_tx_if: step-command handshake between a command source and quad_step_tx
//   cmd_valid  source -> tx  command present
//   cmd_ready  tx -> source  transmitter idle and able to accept
//   cmd_dir    source -> tx  1 = forward (A leads B), 0 = reverse
//   cmd_steps  source -> tx  quadrature steps to emit, 0 allowed
interface quad_step_tx_if #(parameter int CW = 8);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_dir;
  logic [CW-1:0] cmd_steps;
  modport master (output cmd_valid, cmd_dir, cmd_steps, input cmd_ready);
  modport slave  (input cmd_valid, cmd_dir, cmd_steps, output cmd_ready);
endinterface

// File: rtl/quad_step_tx.sv
// quad_step_tx: turns step commands into a DWELL-spaced Gray-coded A/B quadrature waveform
//   clk   system clock
//   rst   asynchronous active-low reset
//   cmd   step-command handshake (quad_step_tx_if.slave)
//   a, b  registered quadrature phases
//   busy  command in progress
//   done  one-cycle pulse when a command completes
//   pos   16-bit wrapping count of emitted steps (+1 forward, -1 reverse)
//   z     index pulse, high while the phase counter is 0 (only with QTX_INDEX_EN)
// Optional feature macro: QTX_INDEX_EN adds the z output and a 0..4*PPR-1 phase counter.
module quad_step_tx #(
  parameter int DWELL = 100,
  parameter int CW    = 8,
  parameter int PPR   = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  quad_step_tx_if.slave        cmd,
  output logic                 a,
  output logic                 b,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          pos
`ifdef QTX_INDEX_EN
  ,
  output logic                 z
`endif
);
  if (DWELL < 2 || PPR < 1) begin : g_bad_param
    $error("quad_step_tx: DWELL must be >= 2 and PPR >= 1");
  end
  localparam int TW = $clog2(DWELL);
  typedef enum logic [1:0] {IDLE, STEP, HOLD, DONE} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [1:0]    ab_q, ab_d;
  logic [15:0]   pos_q, pos_d;
  logic          dir_q, dir_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  // STEP itself is one of the DWELL cycles between edges, so HOLD lasts DWELL-1 cycles.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    tmr_d   = tmr_q;
    ab_d    = ab_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    case (state_q)
      IDLE: if (cmd.cmd_valid && ready_q) begin
        dir_d   = cmd.cmd_dir;
        rem_d   = cmd.cmd_steps;
        state_d = (cmd.cmd_steps != '0) ? STEP : DONE;
      end
      STEP: begin
        ab_d    = dir_q ? {~ab_q[0], ab_q[1]} : {ab_q[0], ~ab_q[1]};
        pos_d   = dir_q ? pos_q + 16'd1 : pos_q - 16'd1;
        rem_d   = rem_q - 1'b1;
        tmr_d   = TW'(DWELL - 2);
        state_d = HOLD;
      end
      HOLD: if (tmr_q == '0) state_d = (rem_q != '0) ? STEP : DONE;
            else tmr_d = tmr_q - 1'b1;
      default: state_d = IDLE;
    endcase
    // ready is withheld for the cycle after DONE so done and ready never overlap.
    ready_d = (state_d == IDLE) && (state_q != DONE);
    busy_d  = (state_q == STEP) || (state_q == HOLD);
    done_d  = state_q == DONE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      tmr_q   <= '0;
      ab_q    <= 2'b00;
      pos_q   <= '0;
      dir_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      tmr_q   <= tmr_d;
      ab_q    <= ab_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign cmd.cmd_ready = ready_q;
  assign a    = ab_q[1];
  assign b    = ab_q[0];
  assign busy = busy_q;
  assign done = done_q;
  assign pos  = pos_q;
`ifdef QTX_INDEX_EN
  localparam int IW = $clog2(4 * PPR);
  localparam logic [IW-1:0] IMAX = IW'(4 * PPR - 1);
  logic [IW-1:0] idx_q, idx_d;
  logic          z_q, z_d;
  always_comb begin
    idx_d = idx_q;
    if (state_q == STEP)
      idx_d = dir_q ? ((idx_q == IMAX) ? '0 : idx_q + 1'b1)
                    : ((idx_q == '0) ? IMAX : idx_q - 1'b1);
    z_d = idx_d == '0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q <= '0;
      z_q   <= 1'b1;
    end else begin
      idx_q <= idx_d;
      z_q   <= z_d;
    end
  end
  assign z = z_q;
`endif
endmodule

// File: tb/tb_quad_step_tx.sv
// tb_quad_step_tx: directed self-checking bench for quad_step_tx (DWELL=4, CW=8, PPR=2)
module tb_quad_step_tx;
  localparam int DWELL = 4;
  localparam int CW    = 8;
  localparam int PPR   = 2;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        a, b, busy, done;
  logic [15:0] pos;
`ifdef QTX_INDEX_EN
  logic        z;
`endif
  int errors = 0;
  int checks = 0;
  quad_step_tx_if #(.CW(CW)) cmd_if ();
  quad_step_tx #(.DWELL(DWELL), .CW(CW), .PPR(PPR)) dut (
    .clk(clk), .rst(rst), .cmd(cmd_if), .a(a), .b(b),
    .busy(busy), .done(done), .pos(pos)
`ifdef QTX_INDEX_EN
    , .z(z)
`endif
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  // Drive a command at a negedge; returns one negedge later (cycle 0 = just after accept edge).
  task automatic send(input logic dir, input logic [CW-1:0] steps);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_dir   = dir;
    cmd_if.cmd_steps = steps;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
  endtask
  task automatic wait_ready();
    int n = 0;
    while (cmd_if.cmd_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cmd_if.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL wait_ready: cmd_ready=%b required 1 within 200 cycles", cmd_if.cmd_ready);
    end
  endtask
  task automatic test_reset();
    rst = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_dir   = 1'b0;
    cmd_if.cmd_steps = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({a, b} !== 2'b00) begin errors++; $display("FAIL reset_ab: got %b expected 00", {a, b}); end
    checks++; if (pos !== 16'h0000) begin errors++; $display("FAIL reset_pos: got %h expected 0000", pos); end
    checks++; if (cmd_if.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", cmd_if.cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if ({done, busy, a, b} !== 4'b0000 || cmd_if.cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL idle cycle %0d: done/busy/a/b=%b ready=%b expected 0000 ready 1", c, {done, busy, a, b}, cmd_if.cmd_ready);
      end
    end
  endtask
  task automatic test_reset_mid();
    send(1'b1, 8'd5);
    repeat (7) @(negedge clk);
    checks++; if ({a, b} !== 2'b11) begin errors++; $display("FAIL mid_pre_ab: got %b expected 11", {a, b}); end
    checks++; if (pos !== 16'd2) begin errors++; $display("FAIL mid_pre_pos: got %h expected 0002", pos); end
    rst = 1'b0;
    #1;
    checks++; if ({a, b} !== 2'b00) begin errors++; $display("FAIL mid_ab: got %b expected 00", {a, b}); end
    checks++; if (pos !== 16'd0) begin errors++; $display("FAIL mid_pos: got %h expected 0000", pos); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
    checks++; if (cmd_if.cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b expected 1", cmd_if.cmd_ready); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || {a, b} !== 2'b00) begin
        errors++;
        $display("FAIL mid_after cycle %0d: done=%b ab=%b expected done 0 ab 00", c, done, {a, b});
      end
    end
  endtask
  task automatic test_forward();
    logic [1:0] exp_ab;
    logic       exp_busy, exp_done, exp_ready;
    wait_ready();
    send(1'b1, 8'd3);
    checks++; if ({a, b, busy, cmd_if.cmd_ready} !== 4'b0000) begin errors++; $display("FAIL fwd_c0: ab/busy/ready=%b expected 0000", {a, b, busy, cmd_if.cmd_ready}); end
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      exp_ab    = (c < 5) ? 2'b10 : (c < 9) ? 2'b11 : 2'b01;
      exp_busy  = c <= 12;
      exp_done  = c == 13;
      exp_ready = c >= 14;
      checks++; if ({a, b} !== exp_ab) begin errors++; $display("FAIL fwd_ab cycle %0d: got %b expected %b", c, {a, b}, exp_ab); end
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL fwd_busy cycle %0d: got %b expected %b", c, busy, exp_busy); end
      checks++; if (done !== exp_done) begin errors++; $display("FAIL fwd_done cycle %0d: got %b expected %b", c, done, exp_done); end
      checks++; if (cmd_if.cmd_ready !== exp_ready) begin errors++; $display("FAIL fwd_ready cycle %0d: got %b expected %b", c, cmd_if.cmd_ready, exp_ready); end
    end
    checks++; if (pos !== 16'h0003) begin errors++; $display("FAIL fwd_pos: got %h expected 0003", pos); end
  endtask
  task automatic test_reverse_wrap();
    logic [1:0]  first_ab  [2] = '{2'b11, 2'b00};
    logic [1:0]  second_ab [2] = '{2'b10, 2'b01};
    logic [15:0] end_pos   [2] = '{16'h0001, 16'hFFFF};
    logic [1:0]  exp_ab;
    for (int k = 0; k < 2; k++) begin
      wait_ready();
      send(1'b0, 8'd2);
      for (int c = 1; c <= 10; c++) begin
        @(negedge clk);
        exp_ab = (c < 5) ? first_ab[k] : second_ab[k];
        checks++; if ({a, b} !== exp_ab) begin errors++; $display("FAIL rev%0d_ab cycle %0d: got %b expected %b", k, c, {a, b}, exp_ab); end
        checks++; if (done !== (c == 9)) begin errors++; $display("FAIL rev%0d_done cycle %0d: got %b expected %b", k, c, done, c == 9); end
      end
      checks++; if (pos !== end_pos[k]) begin errors++; $display("FAIL rev%0d_pos: got %h expected %h", k, pos, end_pos[k]); end
    end
  endtask
  task automatic test_zero_step();
    wait_ready();
    send(1'b1, 8'd0);
    checks++; if ({done, busy, cmd_if.cmd_ready} !== 3'b000) begin errors++; $display("FAIL zero_c0: done/busy/ready=%b expected 000", {done, busy, cmd_if.cmd_ready}); end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b expected 1", done); end
    checks++; if ({busy, cmd_if.cmd_ready} !== 2'b00) begin errors++; $display("FAIL zero_busy_ready: got %b expected 00", {busy, cmd_if.cmd_ready}); end
    checks++; if ({a, b} !== 2'b01) begin errors++; $display("FAIL zero_ab: got %b expected 01", {a, b}); end
    checks++; if (pos !== 16'hFFFF) begin errors++; $display("FAIL zero_pos: got %h expected FFFF", pos); end
    @(negedge clk);
    checks++; if ({done, cmd_if.cmd_ready} !== 2'b01) begin errors++; $display("FAIL zero_c2: done/ready=%b expected 01", {done, cmd_if.cmd_ready}); end
  endtask
  task automatic test_valid_held();
    logic [1:0] exp_ab;
    logic       exp_ready, exp_busy, exp_done;
    wait_ready();
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_dir   = 1'b1;
    cmd_if.cmd_steps = 8'd1;
    @(negedge clk);
    cmd_if.cmd_dir   = 1'b0;
    cmd_if.cmd_steps = 8'd2;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      exp_ab    = (c <= 7) ? 2'b00 : (c <= 11) ? 2'b01 : 2'b11;
      exp_ready = (c == 6) || (c == 17);
      exp_busy  = (c >= 1 && c <= 4) || (c >= 8 && c <= 15);
      exp_done  = (c == 5) || (c == 16);
      checks++; if ({a, b} !== exp_ab) begin errors++; $display("FAIL held_ab cycle %0d: got %b expected %b", c, {a, b}, exp_ab); end
      checks++; if (cmd_if.cmd_ready !== exp_ready) begin errors++; $display("FAIL held_ready cycle %0d: got %b expected %b", c, cmd_if.cmd_ready, exp_ready); end
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL held_busy cycle %0d: got %b expected %b", c, busy, exp_busy); end
      checks++; if (done !== exp_done) begin errors++; $display("FAIL held_done cycle %0d: got %b expected %b", c, done, exp_done); end
      if (c == 8) cmd_if.cmd_valid = 1'b0;
    end
    checks++; if (pos !== 16'hFFFE) begin errors++; $display("FAIL held_pos: got %h expected FFFE", pos); end
  endtask
`ifdef QTX_INDEX_EN
  task automatic test_index();
    logic exp_z;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (z !== 1'b1) begin errors++; $display("FAIL idx_reset_z: got %b expected 1", z); end
    send(1'b1, 8'd8);
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      exp_z = c >= 29;
      checks++; if (z !== exp_z) begin errors++; $display("FAIL idx_z cycle %0d: got %b expected %b", c, z, exp_z); end
    end
    checks++; if (dut.idx_q !== 3'd0) begin errors++; $display("FAIL idx_fwd: got %0d expected 0", dut.idx_q); end
    wait_ready();
    send(1'b0, 8'd1);
    @(negedge clk);
    checks++; if (z !== 1'b0) begin errors++; $display("FAIL idx_rev_z: got %b expected 0", z); end
    checks++; if (dut.idx_q !== 3'd7) begin errors++; $display("FAIL idx_rev: got %0d expected 7", dut.idx_q); end
    checks++; if ({a, b} !== 2'b01) begin errors++; $display("FAIL idx_rev_ab: got %b expected 01", {a, b}); end
  endtask
`endif
  initial begin
    test_reset();
    test_reset_mid();
    test_forward();
    test_reverse_wrap();
    test_zero_step();
    test_valid_held();
`ifdef QTX_INDEX_EN
    test_index();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
